wlan_scrambler_tx: RTL and testbench
====================================

Name: wlan_scrambler_tx

Overview:
- Transmit-side 802.11a/g data scrambler. It is the counterpart of the receive-side descrambler and uses the same x^7 + x^4 + 1 polynomial.
- Sits between the PSDU bit source (SERVICE + PSDU bits) and the convolutional encoder.
- Per frame: loads a 7-bit seed, scrambles one bit per accepted cycle, then generates the TAIL_LEN tail bits itself. Tail bits go out forced to zero while the LFSR keeps advancing.

Parameters:
- SEED_DEFAULT, 7'h5D, seed substituted when an all-zero seed is requested.
- TAIL_LEN, 6, number of zeroed tail bits appended after in_last. Range 0..15.
- CNT_W, 12, width of the data bit counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- seed  input  7  initial LFSR state. seed[6]=x7 … seed[0]=x1.
- seed_load  input  1  start (or restart) a frame with seed.
- data_in  input  1  plaintext bit.
- in_valid  input  1  data_in valid.
- in_last  input  1  marks the final data bit of the frame. Qualified by in_valid.
- in_ready  output  1  block accepts a data bit this cycle.
- data_out  output  1  scrambled bit.
- out_valid  output  1  data_out valid.
- out_tail  output  1  current output is a tail bit.
- out_last  output  1  final output bit of the frame.
- seed_err  output  1  one-cycle pulse: zero seed was replaced.
- frame_abort  output  1  one-cycle pulse: frame restarted before completion.
- bit_cnt  output  CNT_W  data bits accepted in the current frame. Saturates at all-ones.

Behaviour:
- Reset:
  - All outputs are 0 and the state is IDLE.
  - LFSR = SEED_DEFAULT, bit_cnt = 0.
  - Reset wins over every other input. It takes effect at the same clock edge, mid-frame included.
- LFSR update:
  - fb = s[6] ^ s[3].
  - On advance, s <= {s[5:0], fb}.
  - Scrambled bit = data_in ^ fb.
- States: IDLE, RUN, TAIL. in_ready = (state == RUN).
- IDLE:
  - in_valid is ignored and out_valid stays 0.
  - seed_load → load LFSR, clear bit_cnt, go to RUN next cycle.
- RUN:
  - Accept occurs when in_valid && in_ready.
  - On accept: register data_out = data_in ^ fb, set out_valid = 1 the next cycle (latency 1), advance the LFSR, increment bit_cnt.
  - No accept → out_valid = 0 next cycle and the LFSR holds.
- in_last on an accepted bit:
  - TAIL_LEN > 0 → go to TAIL with tail_cnt = 0.
  - TAIL_LEN = 0 → that bit's output carries out_last = 1, then go to IDLE.
- TAIL:
  - Each cycle: out_valid = 1 next cycle, data_out = 0, out_tail = 1, LFSR advances.
  - On the TAIL_LEN-th tail bit, out_last = 1, then go to IDLE.
  - in_ready = 0 throughout.
- Seed handling:
  - seed_load with seed == 0 → load SEED_DEFAULT and pulse seed_err the next cycle.
- seed_load in RUN or TAIL:
  - Aborts the frame and pulses frame_abort the next cycle.
  - Reloads the LFSR, clears bit_cnt, goes to RUN.
  - A data bit presented that cycle is dropped (no output). out_valid = 0 next cycle and out_last is not asserted.
- Held inputs:
  - seed_load held high in RUN restarts the frame every cycle. This is legal but no data is accepted.
  - in_last without in_valid is ignored.
- Output rules:
  - out_tail and out_last are only ever 1 when out_valid = 1.
  - The LFSR period is 127 bits. There is no special handling at wrap-around.

Test Plan:
- Seed 7'h7F, 8 zero bits with in_last on the 8th, TAIL_LEN=6 → data_out 0,0,0,0,1,1,1,0, then 6 zero outputs with out_tail=1. out_last is high only on output 14, the first out_valid comes 1 cycle after the first accept, and bit_cnt = 8.
- Seed 7'h7F, 8 one bits → data_out 1,1,1,1,0,0,0,1. Feed 127 zero bits → output is the 127-bit 802.11 sequence beginning 00001110 11110010 11001001, and bit 128 equals bit 1 (period 127).
- Seed 0, 16 zero bits → seed_err single pulse; outputs are bit-identical to a run with explicit seed 7'h5D.
- Abort: seed_load asserted during tail bit 3, data in_valid gaps (toggle every other cycle) beforehand → frame_abort single pulse, out_last never asserted for the aborted frame, in_ready=1 the next cycle, new frame scrambles from the new seed. During gaps, out_valid=0 and the LFSR holds (gapped output equals the contiguous run).
- Reset asserted mid-RUN after 5 accepted bits → outputs 0, in_ready=0, bit_cnt=0 on the next cycle. in_valid is ignored until seed_load.
- TAIL_LEN=0 build, 3 bits with in_last on the 3rd → out_last on the 3rd output, out_tail never 1, IDLE next cycle.

Source files
------------

// File: rtl/wlan_scrambler_tx.sv
// rtl/wlan_scrambler_tx.sv - 802.11a/g transmit scrambler (x^7 + x^4 + 1) with generated zero tail
module wlan_scrambler_tx #(
   parameter logic [6:0] SEED_DEFAULT = 7'h5D,
   parameter int         TAIL_LEN     = 6,
   parameter int         CNT_W        = 12
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [6:0]       seed,
   input  logic             seed_load,
   input  logic             data_in,
   input  logic             in_valid,
   input  logic             in_last,
   output logic             in_ready,
   output logic             data_out,
   output logic             out_valid,
   output logic             out_tail,
   output logic             out_last,
   output logic             seed_err,
   output logic             frame_abort,
   output logic [CNT_W-1:0] bit_cnt
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_TAIL = 2'd2
   } state_t;

   // Index of the final tail bit; irrelevant when no tail is generated.
   localparam logic [3:0] TAIL_LAST = (TAIL_LEN > 0) ? 4'(TAIL_LEN - 1) : 4'd0;

   state_t           r_state;
   logic [6:0]       r_lfsr;
   logic [3:0]       r_tail_cnt;
   logic [CNT_W-1:0] r_bit_cnt;
   logic             r_data_out;
   logic             r_out_valid;
   logic             r_out_tail;
   logic             r_out_last;
   logic             r_seed_err;
   logic             r_frame_abort;

   logic             w_fb;
   logic             w_accept;
   logic             w_seed_zero;
   logic [6:0]       w_load_seed;
   logic             w_cnt_sat;

   assign w_fb        = r_lfsr[6] ^ r_lfsr[3];
   assign w_accept    = in_valid && (r_state == S_RUN);
   assign w_seed_zero = (seed == 7'd0);
   assign w_load_seed = w_seed_zero ? SEED_DEFAULT : seed;
   assign w_cnt_sat   = (r_bit_cnt == {CNT_W{1'b1}});

   assign in_ready    = (r_state == S_RUN);
   assign data_out    = r_data_out;
   assign out_valid   = r_out_valid;
   assign out_tail    = r_out_tail;
   assign out_last    = r_out_last;
   assign seed_err    = r_seed_err;
   assign frame_abort = r_frame_abort;
   assign bit_cnt     = r_bit_cnt;

   // Frame FSM, LFSR and registered outputs; seed_load overrides any state, reset overrides all.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state       <= S_IDLE;
         r_lfsr        <= SEED_DEFAULT;
         r_tail_cnt    <= 4'd0;
         r_bit_cnt     <= '0;
         r_data_out    <= 1'b0;
         r_out_valid   <= 1'b0;
         r_out_tail    <= 1'b0;
         r_out_last    <= 1'b0;
         r_seed_err    <= 1'b0;
         r_frame_abort <= 1'b0;
      end else begin
         r_data_out    <= 1'b0;
         r_out_valid   <= 1'b0;
         r_out_tail    <= 1'b0;
         r_out_last    <= 1'b0;
         r_seed_err    <= 1'b0;
         r_frame_abort <= 1'b0;
         if (seed_load) begin
            // A restart drops any bit presented this cycle and never closes the old frame.
            r_lfsr        <= w_load_seed;
            r_bit_cnt     <= '0;
            r_tail_cnt    <= 4'd0;
            r_state       <= S_RUN;
            r_seed_err    <= w_seed_zero;
            r_frame_abort <= (r_state != S_IDLE);
         end else begin
            case (r_state)
               S_IDLE: begin
                  r_state <= S_IDLE;
               end
               S_RUN: begin
                  if (w_accept) begin
                     r_data_out  <= data_in ^ w_fb;
                     r_out_valid <= 1'b1;
                     r_lfsr      <= {r_lfsr[5:0], w_fb};
                     if (!w_cnt_sat) begin
                        r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                     end
                     if (in_last) begin
                        if (TAIL_LEN > 0) begin
                           r_state    <= S_TAIL;
                           r_tail_cnt <= 4'd0;
                        end else begin
                           r_out_last <= 1'b1;
                           r_state    <= S_IDLE;
                        end
                     end
                  end
               end
               S_TAIL: begin
                  // Tail bits are forced to zero but the scrambler sequence keeps running.
                  r_out_valid <= 1'b1;
                  r_out_tail  <= 1'b1;
                  r_lfsr      <= {r_lfsr[5:0], w_fb};
                  r_tail_cnt  <= r_tail_cnt + 4'd1;
                  if (r_tail_cnt == TAIL_LAST) begin
                     r_out_last <= 1'b1;
                     r_state    <= S_IDLE;
                  end
               end
               default: begin
                  r_state <= S_IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_wlan_scrambler_tx.sv
// tb/tb_wlan_scrambler_tx.sv - directed self-checking bench for wlan_scrambler_tx
module tb_wlan_scrambler_tx;

   logic        clk = 1'b0;
   logic        reset;
   logic [6:0]  seed;
   logic        seed_load;
   logic        data_in;
   logic        in_valid;
   logic        in_last;

   logic        in_ready, data_out, out_valid, out_tail, out_last, seed_err, frame_abort;
   logic [11:0] bit_cnt;
   logic        in_ready_z, data_out_z, out_valid_z, out_tail_z, out_last_z, seed_err_z, frame_abort_z;
   logic [11:0] bit_cnt_z;

   int n_checks = 0;
   int n_errors = 0;
   int n_seed_err;
   int n_abort;

   logic q_d[$];
   logic q_t[$];
   logic q_l[$];
   logic q0_d[$];
   logic q0_t[$];
   logic q0_l[$];

   logic [6:0] m;
   logic       exp_bits[$];
   logic       saved[16];

   always #5 clk = ~clk;

   wlan_scrambler_tx #(.SEED_DEFAULT(7'h5D), .TAIL_LEN(6), .CNT_W(12)) u_dut (
      .clk(clk), .reset(reset), .seed(seed), .seed_load(seed_load),
      .data_in(data_in), .in_valid(in_valid), .in_last(in_last),
      .in_ready(in_ready), .data_out(data_out), .out_valid(out_valid),
      .out_tail(out_tail), .out_last(out_last), .seed_err(seed_err),
      .frame_abort(frame_abort), .bit_cnt(bit_cnt)
   );

   wlan_scrambler_tx #(.SEED_DEFAULT(7'h5D), .TAIL_LEN(0), .CNT_W(12)) u_dut_z (
      .clk(clk), .reset(reset), .seed(seed), .seed_load(seed_load),
      .data_in(data_in), .in_valid(in_valid), .in_last(in_last),
      .in_ready(in_ready_z), .data_out(data_out_z), .out_valid(out_valid_z),
      .out_tail(out_tail_z), .out_last(out_last_z), .seed_err(seed_err_z),
      .frame_abort(frame_abort_z), .bit_cnt(bit_cnt_z)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference scrambler: returns the scrambled bit and advances the model state.
   function automatic logic m_step(input logic d);
      logic f;
      f = m[6] ^ m[3];
      m = {m[5:0], f};
      return d ^ f;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
      check("qual", 32'((out_tail | out_last) & ~out_valid), 32'd0);
      check("qual_z", 32'((out_tail_z | out_last_z) & ~out_valid_z), 32'd0);
      if (out_valid) begin
         q_d.push_back(data_out);
         q_t.push_back(out_tail);
         q_l.push_back(out_last);
      end
      if (out_valid_z) begin
         q0_d.push_back(data_out_z);
         q0_t.push_back(out_tail_z);
         q0_l.push_back(out_last_z);
      end
      n_seed_err += int'(seed_err);
      n_abort    += int'(frame_abort);
   endtask

   task automatic clear();
      q_d.delete(); q_t.delete(); q_l.delete();
      q0_d.delete(); q0_t.delete(); q0_l.delete();
      exp_bits.delete();
      n_seed_err = 0;
      n_abort    = 0;
   endtask

   task automatic start(input logic [6:0] s);
      seed = s;
      seed_load = 1'b1;
      tick();
      seed_load = 1'b0;
      m = (s == 7'd0) ? 7'h5D : s;
   endtask

   task automatic send(input logic b, input logic last);
      data_in  = b;
      in_valid = 1'b1;
      in_last  = last;
      exp_bits.push_back(m_step(b));
      tick();
      in_valid = 1'b0;
      in_last  = 1'b0;
      data_in  = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   function automatic int count_ones(input logic q[$]);
      int c = 0;
      foreach (q[i]) c += int'(q[i]);
      return c;
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [7:0]  e_zero;
      logic [7:0]  e_ones;
      logic [23:0] e_seq;
      logic [5:0]  pat;
      e_zero = 8'b0000_1110;
      e_ones = 8'b1111_0001;
      e_seq  = 24'b00001110_11110010_11001001;
      pat    = 6'b101100;

      reset = 1'b1; seed = 7'd0; seed_load = 1'b0;
      data_in = 1'b0; in_valid = 1'b0; in_last = 1'b0;
      clear();
      idle(3);
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_data", 32'(data_out), 32'd0);
      check("rst_ready", 32'(in_ready), 32'd0);
      check("rst_cnt", 32'(bit_cnt), 32'd0);
      check("rst_pulses", 32'({out_tail, out_last, seed_err, frame_abort}), 32'd0);
      reset = 1'b0;
      tick();

      // Seed 7F, eight zero data bits, six tail bits.
      clear();
      start(7'h7F);
      check("t1_ready", 32'(in_ready), 32'd1);
      check("t1_novalid", 32'(out_valid), 32'd0);
      for (int i = 0; i < 8; i++) begin
         send(1'b0, i == 7);
         if (i == 0) check("t1_latency", 32'(out_valid), 32'd1);
      end
      idle(8);
      check("t1_idle_ready", 32'(in_ready), 32'd0);
      check("t1_cnt", 32'(bit_cnt), 32'd8);
      check("t1_len", 32'(q_d.size()), 32'd14);
      for (int i = 0; i < 8; i++) begin
         check("t1_data", 32'(q_d[i]), 32'(e_zero[7-i]));
         check("t1_notail", 32'(q_t[i]), 32'd0);
      end
      for (int i = 8; i < 14; i++) begin
         check("t1_tail_data", 32'(q_d[i]), 32'd0);
         check("t1_tail_flag", 32'(q_t[i]), 32'd1);
      end
      check("t1_last_cnt", 32'(count_ones(q_l)), 32'd1);
      check("t1_last_pos", 32'(q_l[13]), 32'd1);

      // Seed 7F, eight one bits.
      clear();
      start(7'h7F);
      for (int i = 0; i < 8; i++) send(1'b1, i == 7);
      idle(8);
      for (int i = 0; i < 8; i++) check("t2_ones", 32'(q_d[i]), 32'(e_ones[7-i]));

      // Seed 7F, 128 zero bits: the raw scrambler sequence and its period.
      clear();
      start(7'h7F);
      for (int i = 0; i < 128; i++) send(1'b0, i == 127);
      idle(8);
      check("t2_cnt", 32'(bit_cnt), 32'd128);
      for (int i = 0; i < 24; i++) check("t2_seq_head", 32'(q_d[i]), 32'(e_seq[23-i]));
      for (int i = 0; i < 128; i++) check("t2_seq_model", 32'(q_d[i]), 32'(exp_bits[i]));
      check("t2_period", 32'(q_d[127]), 32'(q_d[0]));

      // Zero seed falls back to the default seed and flags it once.
      clear();
      start(7'h00);
      check("t3_seed_err_pulse", 32'(seed_err), 32'd1);
      for (int i = 0; i < 16; i++) send(1'b0, i == 15);
      idle(8);
      check("t3_seed_err_count", 32'(n_seed_err), 32'd1);
      for (int i = 0; i < 16; i++) saved[i] = q_d[i];
      clear();
      start(7'h5D);
      check("t3_no_seed_err", 32'(seed_err), 32'd0);
      for (int i = 0; i < 16; i++) send(1'b0, i == 15);
      idle(8);
      for (int i = 0; i < 16; i++) begin
         check("t3_same_as_5d", 32'(saved[i]), 32'(q_d[i]));
         check("t3_model_5d", 32'(q_d[i]), 32'(exp_bits[i]));
      end

      // Gapped input then abort during the third tail bit.
      clear();
      start(7'h7F);
      for (int i = 0; i < 6; i++) begin
         if (i > 0) tick();
         send(pat[5-i], i == 5);
      end
      idle(2);
      seed = 7'h2A; seed_load = 1'b1;
      in_valid = 1'b1; data_in = 1'b1;
      tick();
      seed_load = 1'b0; in_valid = 1'b0; data_in = 1'b0;
      check("t4_abort_pulse", 32'(frame_abort), 32'd1);
      check("t4_abort_novalid", 32'(out_valid), 32'd0);
      check("t4_abort_nolast", 32'(out_last), 32'd0);
      check("t4_abort_ready", 32'(in_ready), 32'd1);
      check("t4_abort_cnt", 32'(bit_cnt), 32'd0);
      check("t4_len", 32'(q_d.size()), 32'd8);
      check("t4_no_last", 32'(count_ones(q_l)), 32'd0);
      for (int i = 0; i < 6; i++) check("t4_gap_data", 32'(q_d[i]), 32'(exp_bits[i]));
      check("t4_tail_flags", 32'({q_t[6], q_t[7]}), 32'd3);
      clear();
      m = 7'h2A;
      for (int i = 0; i < 8; i++) send(1'b0, i == 7);
      idle(8);
      check("t4_abort_single", 32'(n_abort), 32'd0);
      for (int i = 0; i < 8; i++) check("t4_new_seed", 32'(q_d[i]), 32'(exp_bits[i]));

      // Reset mid-frame after five accepted bits.
      clear();
      start(7'h7F);
      for (int i = 0; i < 5; i++) send(1'b1, 1'b0);
      check("t5_cnt_before", 32'(bit_cnt), 32'd5);
      in_valid = 1'b1; data_in = 1'b1;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("t5_valid", 32'(out_valid), 32'd0);
      check("t5_data", 32'(data_out), 32'd0);
      check("t5_ready", 32'(in_ready), 32'd0);
      check("t5_cnt", 32'(bit_cnt), 32'd0);
      idle(3);
      in_valid = 1'b0; data_in = 1'b0;
      check("t5_ignored", 32'(q_d.size()), 32'd5);
      check("t5_ready_after", 32'(in_ready), 32'd0);

      // Zero-length tail build.
      clear();
      start(7'h7F);
      check("t6_pulses_z", 32'({seed_err_z, frame_abort_z}), 32'd0);
      send(1'b1, 1'b0);
      send(1'b0, 1'b0);
      send(1'b1, 1'b1);
      check("t6_last", 32'(out_last_z), 32'd1);
      check("t6_last_valid", 32'(out_valid_z), 32'd1);
      tick();
      check("t6_idle", 32'(in_ready_z), 32'd0);
      check("t6_cnt", 32'(bit_cnt_z), 32'd3);
      idle(8);
      check("t6_len", 32'(q0_d.size()), 32'd3);
      check("t6_no_tail", 32'(count_ones(q0_t)), 32'd0);
      check("t6_last_count", 32'(count_ones(q0_l)), 32'd1);
      check("t6_data", 32'({q0_d[0], q0_d[1], q0_d[2]}), 32'b101);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
